mor1kx_cache_refill_writer: RTL and testbench

Write-side sequencer that sits directly upstream of the single-clock true dual-port cache data RAM and drives one of its ports.
- After reset, or on request, it clears the whole RAM with an init sweep.
- On a miss it refills one cache line from bus beats, critical word first, with wrap-around inside the line.
- It forwards the critical word to the LSU/fetch stage so that stage can restart early.
- It reports completion or bus error for each refill.

---
 rtl/mor1kx_cache_refill_writer_pkg.sv | 11 +
 rtl/mor1kx_cache_refill_writer_wrap_counter.sv | 24 ++
 rtl/mor1kx_cache_refill_writer.sv | 149 ++++++++++++++
 tb/tb_mor1kx_cache_refill_writer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_cache_refill_writer_pkg.sv
// Shared definitions for the cache refill writer.
// state_t : sequencer state encoding (INIT sweep, IDLE, REFILL line fill).
package mor1kx_cache_refill_writer_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

endpackage

// File: rtl/mor1kx_cache_refill_writer_wrap_counter.sv
// mor1kx_wrap_counter: WIDTH-bit counter with synchronous load and
// increment that wraps modulo 2^WIDTH, plus a terminal-count flag.
// Ports: clk, rst (async high), load/load_val, inc, count, tc (count is all ones).
module mor1kx_wrap_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       count <= '0;
        else if (load) count <= load_val;
        else if (inc)  count <= count + 1'b1;   // natural wrap, no carry out
    end

    assign tc = &count;

endmodule

// File: rtl/mor1kx_cache_refill_writer.sv
// mor1kx_cache_refill_writer: drives one write port of the cache data RAM.
// Clears the RAM after reset or on invalidate, and refills one line from
// bus beats critical-word-first with wrap inside the line.
// Ports:
//   clk, rst                 clock, async active-high reset
//   invalidate_i             request full clear sweep (IDLE only)
//   refill_req_i/addr_i      start refill at critical word address (IDLE only)
//   bus_req_o/adr_o          bus cycle request and beat address
//   bus_dat_i/ack_i/err_i    beat data, accept, error
//   ram_addr_o/we_o/din_o    RAM write port
//   crit_valid_o/dat_o       critical-word pulse and held data
//   refill_busy_o/done_o/err_o  status
//   init_done_o              first sweep complete (sticky)
module mor1kx_cache_refill_writer
    import mor1kx_cache_refill_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  invalidate_i,
    input  logic                  refill_req_i,
    input  logic [ADDR_WIDTH-1:0] refill_addr_i,
    output logic                  bus_req_o,
    output logic [ADDR_WIDTH-1:0] bus_adr_o,
    input  logic [DATA_WIDTH-1:0] bus_dat_i,
    input  logic                  bus_ack_i,
    input  logic                  bus_err_i,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [DATA_WIDTH-1:0] ram_din_o,
    output logic                  crit_valid_o,
    output logic [DATA_WIDTH-1:0] crit_dat_o,
    output logic                  refill_busy_o,
    output logic                  refill_done_o,
    output logic                  refill_err_o,
    output logic                  init_done_o
);

    localparam logic [LINE_WIDTH:0] LAST_BEAT = {1'b0, {LINE_WIDTH{1'b1}}};

    state_t                         state, state_nxt;
    logic [ADDR_WIDTH-1:0]          sweep;
    logic [ADDR_WIDTH-LINE_WIDTH-1:0] base;
    logic [LINE_WIDTH-1:0]          offset;
    logic [LINE_WIDTH:0]            beats;
    logic                           unused_off_tc;

    logic ack_ok, start, sweep_last, last_beat;

    assign ack_ok     = (state == ST_REFILL) && bus_ack_i && !bus_err_i;
    assign start      = (state == ST_IDLE) && !invalidate_i && refill_req_i;
    assign sweep_last = &sweep;
    assign last_beat  = (beats == LAST_BEAT);

    // Offset within the line; wraps so the fill never leaves the line.
    mor1kx_wrap_counter #(.WIDTH(LINE_WIDTH)) u_offset (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (refill_addr_i[LINE_WIDTH-1:0]),
        .inc      (ack_ok),
        .count    (offset),
        .tc       (unused_off_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        bus_req_o  = 1'b0;
        bus_adr_o  = '0;
        ram_addr_o = '0;
        ram_we_o   = 1'b0;
        ram_din_o  = '0;
        case (state)
            ST_INIT: begin
                ram_we_o   = 1'b1;
                ram_addr_o = sweep;
                if (sweep_last) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (invalidate_i)      state_nxt = ST_INIT;
                else if (refill_req_i) state_nxt = ST_REFILL;
            end
            ST_REFILL: begin
                bus_req_o  = 1'b1;
                bus_adr_o  = {base, offset};
                ram_addr_o = {base, offset};
                ram_din_o  = bus_dat_i;
                ram_we_o   = ack_ok;
                if (bus_err_i || (bus_ack_i && last_beat)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep         <= '0;
            base          <= '0;
            beats         <= '0;
            crit_valid_o  <= 1'b0;
            crit_dat_o    <= '0;
            refill_done_o <= 1'b0;
            refill_err_o  <= 1'b0;
            init_done_o   <= 1'b0;
        end else begin
            crit_valid_o  <= 1'b0;
            refill_done_o <= 1'b0;
            refill_err_o  <= 1'b0;
            case (state)
                ST_INIT: begin
                    sweep <= sweep + 1'b1;
                    if (sweep_last) init_done_o <= 1'b1;
                end
                ST_IDLE: begin
                    if (invalidate_i) begin
                        sweep <= '0;
                    end else if (refill_req_i) begin
                        base  <= refill_addr_i[ADDR_WIDTH-1:LINE_WIDTH];
                        beats <= '0;
                    end
                end
                ST_REFILL: begin
                    if (bus_err_i) begin
                        refill_err_o <= 1'b1;
                    end else if (bus_ack_i) begin
                        beats <= beats + 1'b1;
                        if (beats == '0) begin
                            crit_dat_o   <= bus_dat_i;
                            crit_valid_o <= 1'b1;
                        end
                        if (last_beat) refill_done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign refill_busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_mor1kx_cache_refill_writer.sv
// Scoreboard bench for mor1kx_cache_refill_writer (ADDR_WIDTH=6, LINE_WIDTH=3).
// Stimulus pushes expected RAM writes; a negedge monitor pops and compares.
module tb_mor1kx_cache_refill_writer;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          invalidate_i, refill_req_i;
    logic [AW-1:0] refill_addr_i;
    logic          bus_req_o;
    logic [AW-1:0] bus_adr_o;
    logic [DW-1:0] bus_dat_i;
    logic          bus_ack_i, bus_err_i;
    logic [AW-1:0] ram_addr_o;
    logic          ram_we_o;
    logic [DW-1:0] ram_din_o;
    logic          crit_valid_o;
    logic [DW-1:0] crit_dat_o;
    logic          refill_busy_o, refill_done_o, refill_err_o, init_done_o;

    mor1kx_cache_refill_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .invalidate_i(invalidate_i), .refill_req_i(refill_req_i), .refill_addr_i(refill_addr_i),
        .bus_req_o(bus_req_o), .bus_adr_o(bus_adr_o), .bus_dat_i(bus_dat_i),
        .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_din_o(ram_din_o),
        .crit_valid_o(crit_valid_o), .crit_dat_o(crit_dat_o),
        .refill_busy_o(refill_busy_o), .refill_done_o(refill_done_o),
        .refill_err_o(refill_err_o), .init_done_o(init_done_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t exp_q[$];

    int checks = 0, errors = 0;
    int n_crit = 0, n_done = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", {26'd0, ram_addr_o}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {26'd0, ram_addr_o}, {26'd0, e.a});
                    chk("wr_data", ram_din_o, e.d);
                end
            end
            if (crit_valid_o)  n_crit++;
            if (refill_done_o) n_done++;
            if (refill_err_o)  n_err++;
        end
    end

    task automatic push_sweep();
        for (int i = 0; i < 64; i++) begin
            wr_t e;
            e.a = AW'(i);
            e.d = '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name, input bit no_bus);
        int n = 0;
        while (refill_busy_o && n < 200) begin
            if (no_bus && bus_req_o) chk({name, "_bus_req"}, 1, 0);
            tick();
            n++;
        end
        chk({name, "_timeout"}, refill_busy_o, 0);
    endtask

    // Refill a line at addr; gap inserts an idle cycle before each beat;
    // err_beat aborts that beat with bus_err_i (8 = none); stop_beat stops
    // driving before that beat (used for the reset-abort case).
    task automatic refill(input logic [AW-1:0] addr, input logic [7:0] dbase,
                          input bit gap, input int err_beat, input int stop_beat);
        refill_req_i = 1'b1; refill_addr_i = addr;
        tick();
        refill_req_i = 1'b0; refill_addr_i = '0;
        chk("busy_in_refill", refill_busy_o, 1);
        chk("bus_req", bus_req_o, 1);
        for (int b = 0; b < 8 && b < stop_beat; b++) begin
            logic [AW-1:0] ea;
            ea = {addr[5:3], addr[2:0] + 3'(b)};
            if (gap) begin
                bus_ack_i = 1'b0;
                #1;
                chk("gap_adr_hold", {26'd0, bus_adr_o}, {26'd0, ea});
                chk("gap_no_we", ram_we_o, 0);
                tick();
            end
            bus_ack_i = 1'b1;
            bus_dat_i = {24'd0, dbase + 8'(b)};
            bus_err_i = (b == err_beat);
            #1;
            chk("beat_adr", {26'd0, bus_adr_o}, {26'd0, ea});
            if (b != err_beat) begin
                wr_t e;
                e.a = ea;
                e.d = bus_dat_i;
                exp_q.push_back(e);
            end
            tick();
            bus_ack_i = 1'b0; bus_err_i = 1'b0;
            if (b == 0 && err_beat != 0) begin
                chk("crit_valid", crit_valid_o, 1);
                chk("crit_dat", crit_dat_o, {24'd0, dbase});
            end
            if (b == err_beat) begin
                chk("err_pulse", refill_err_o, 1);
                chk("err_no_done", refill_done_o, 0);
                chk("err_idle", refill_busy_o, 0);
                break;
            end
            if (b == 7) begin
                chk("done_pulse", refill_done_o, 1);
                chk("done_idle", refill_busy_o, 0);
            end else begin
                chk("no_early_done", refill_done_o, 0);
            end
        end
        bus_ack_i = 1'b0; bus_err_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; invalidate_i = 1'b0; refill_req_i = 1'b0; refill_addr_i = '0;
        bus_dat_i = '0; bus_ack_i = 1'b0; bus_err_i = 1'b0;
        tick(); tick();
        // reset values
        chk("rst_init_done", init_done_o, 0);
        chk("rst_crit_dat", crit_dat_o, 0);
        chk("rst_crit_valid", crit_valid_o, 0);
        chk("rst_busy", refill_busy_o, 1);
        chk("rst_bus_req", bus_req_o, 0);

        // power-up sweep
        push_sweep();
        rst = 1'b0;
        wait_idle("sweep1", 1'b1);
        chk("sweep1_drained", exp_q.size(), 0);
        chk("sweep1_init_done", init_done_o, 1);
        chk("idle_bus_adr", {26'd0, bus_adr_o}, 0);

        // back-to-back acks; writes 0x15,16,17,10..14
        refill(6'h15, 8'hA0, 1'b0, 8, 8);
        chk("r1_drained", exp_q.size(), 0);

        // alternate-cycle acks
        refill(6'h15, 8'hC0, 1'b1, 8, 8);
        chk("r2_drained", exp_q.size(), 0);
        chk("r2_crit_hold", crit_dat_o, 32'hC0);

        // bus error on the 4th beat; only 3 writes
        refill(6'h2A, 8'hD0, 1'b0, 3, 8);
        chk("r3_drained", exp_q.size(), 0);
        tick();
        chk("r3_err_one_cycle", refill_err_o, 0);

        // invalidate wins over refill request
        invalidate_i = 1'b1; refill_req_i = 1'b1; refill_addr_i = 6'h08;
        push_sweep();
        tick();
        invalidate_i = 1'b0; refill_req_i = 1'b0;
        chk("inv_busy", refill_busy_o, 1);
        wait_idle("inv_sweep", 1'b1);
        chk("inv_drained", exp_q.size(), 0);
        chk("inv_init_done_kept", init_done_o, 1);
        tick();
        chk("inv_req_dropped", bus_req_o, 0);

        // reset during beat 5 of a refill
        refill(6'h08, 8'hE0, 1'b0, 8, 4);
        bus_ack_i = 1'b1; bus_dat_i = 32'hE4;
        #1;
        rst = 1'b1;
        #1;
        bus_ack_i = 1'b0;
        chk("arst_bus_req", bus_req_o, 0);
        chk("arst_crit_dat", crit_dat_o, 0);
        chk("arst_init_done", init_done_o, 0);
        chk("arst_busy", refill_busy_o, 1);
        chk("arst_done", refill_done_o, 0);
        chk("r4_drained", exp_q.size(), 0);
        tick();
        push_sweep();
        rst = 1'b0;
        wait_idle("sweep2", 1'b1);
        chk("sweep2_drained", exp_q.size(), 0);
        chk("sweep2_init_done", init_done_o, 1);

        tick();
        chk("n_crit", n_crit, 4);
        chk("n_done", n_done, 2);
        chk("n_err", n_err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
